// File: rtl/ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_pkg
// Description : Shared opcodes, FSM states and control-word types for the
//               multicycle RV32I controller.
// Revision    : 1.0 - initial release
// ============================================================================
package ctrl_pkg;

    localparam logic [6:0] R_TYPE = 7'b0110011;
    localparam logic [6:0] I_TYPE = 7'b0010011;
    localparam logic [6:0] LW     = 7'b0000011;
    localparam logic [6:0] SW     = 7'b0100011;
    localparam logic [6:0] BR     = 7'b1100011;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] HALT   = 7'b1111111;

    localparam logic [1:0] ALUOP_MEM    = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_ARITH  = 2'b10;
    localparam logic [1:0] ALUOP_JUMP   = 2'b11;

    localparam logic [1:0] FAULT_NONE    = 2'b00;
    localparam logic [1:0] FAULT_ILLEGAL = 2'b01;
    localparam logic [1:0] FAULT_TIMEOUT = 2'b10;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALTED = 3'd5,
        S_TRAP   = 3'd6
    } state_e;

    typedef enum logic [1:0] {
        MEM_NONE  = 2'd0,
        MEM_LOAD  = 2'd1,
        MEM_STORE = 2'd2
    } mem_type_e;

    typedef struct packed {
        logic       alu_src;
        logic       mem_to_reg;
        logic [1:0] alu_op;
        logic       jal;
        logic       jalr;
        logic       branch;
        mem_type_e  mem_type;
    } ctrl_word_t;

    localparam ctrl_word_t CTRL_NOP = '{
        alu_src:    1'b0,
        mem_to_reg: 1'b0,
        alu_op:     ALUOP_MEM,
        jal:        1'b0,
        jalr:       1'b0,
        branch:     1'b0,
        mem_type:   MEM_NONE
    };

endpackage : ctrl_pkg
`default_nettype wire

// File: rtl/opcode_decoder.sv
`default_nettype none
// ============================================================================
// Module      : opcode_decoder
// Description : Combinational opcode to control-word decode with legal and
//               halt flags; registered by the controller in DECODE.
// Revision    : 1.0 - initial release
// ============================================================================
module opcode_decoder
    import ctrl_pkg::*;
(
    input  logic [6:0] i_opcode,
    output ctrl_word_t o_ctrl,
    output logic       o_legal,
    output logic       o_halt
);

    always_comb begin
        o_ctrl  = CTRL_NOP;
        o_legal = 1'b1;
        o_halt  = 1'b0;
        case (i_opcode)
            R_TYPE: begin
                o_ctrl.alu_op = ALUOP_ARITH;
            end
            I_TYPE: begin
                o_ctrl.alu_op  = ALUOP_ARITH;
                o_ctrl.alu_src = 1'b1;
            end
            LW: begin
                o_ctrl.alu_op     = ALUOP_MEM;
                o_ctrl.alu_src    = 1'b1;
                o_ctrl.mem_to_reg = 1'b1;
                o_ctrl.mem_type   = MEM_LOAD;
            end
            SW: begin
                o_ctrl.alu_op   = ALUOP_MEM;
                o_ctrl.alu_src  = 1'b1;
                o_ctrl.mem_type = MEM_STORE;
            end
            BR: begin
                o_ctrl.alu_op = ALUOP_BRANCH;
                o_ctrl.branch = 1'b1;
            end
            LUI: begin
                o_ctrl.alu_op  = ALUOP_JUMP;
                o_ctrl.alu_src = 1'b1;
            end
            JAL: begin
                o_ctrl.alu_op = ALUOP_JUMP;
                o_ctrl.jal    = 1'b1;
            end
            JALR: begin
                o_ctrl.alu_op  = ALUOP_JUMP;
                o_ctrl.alu_src = 1'b1;
                o_ctrl.jalr    = 1'b1;
            end
            HALT: begin
                o_halt = 1'b1;
            end
            default: begin
                o_legal = 1'b0;
            end
        endcase
    end

endmodule : opcode_decoder
`default_nettype wire

// File: rtl/multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_controller
// Description : FETCH/DECODE/EXEC/MEM/WB sequencer for the RV32I core with
//               memory handshakes, MEM timeout, sticky halt/fault and a
//               retired-instruction counter. ILLEGAL_TRAP_EN selects trapping
//               on unknown opcodes (default: executed as a NOP).
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_controller
    import ctrl_pkg::*;
#(
    parameter int MEM_WAIT_MAX = 15,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       Opcode,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             imem_req,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic             ALUSrc,
    output logic             MemtoReg,
    output logic             RegWrite,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             Branch,
    output logic             jal,
    output logic             jalr,
    output logic [1:0]       ALUOp,
    output logic             Halt,
    output logic [1:0]       fault,
    output logic             busy,
    output logic [CNT_W-1:0] retired
);

    localparam int                WAIT_W      = $clog2(MEM_WAIT_MAX + 1);
    localparam logic [WAIT_W-1:0] c_wait_last = WAIT_W'(MEM_WAIT_MAX - 1);

    state_e            r_state;
    state_e            w_next_state;
    ctrl_word_t        r_ctrl;
    logic              r_nop;
    logic [WAIT_W-1:0] r_wait;
    logic [1:0]        r_fault;
    logic [CNT_W-1:0]  r_retired;

    ctrl_word_t        w_dec_ctrl;
    logic              w_dec_legal;
    logic              w_dec_halt;
    logic              w_retire;
    logic              w_set_fault;
    logic [1:0]        w_fault_code;
    logic              w_is_load;
    logic              w_is_store;

    opcode_decoder u_opcode_decoder (
        .i_opcode (Opcode),
        .o_ctrl   (w_dec_ctrl),
        .o_legal  (w_dec_legal),
        .o_halt   (w_dec_halt)
    );

    assign w_is_load  = (r_ctrl.mem_type == MEM_LOAD);
    assign w_is_store = (r_ctrl.mem_type == MEM_STORE);

    always_comb begin
        w_next_state = r_state;
        w_retire     = 1'b0;
        w_set_fault  = 1'b0;
        w_fault_code = FAULT_NONE;
        case (r_state)
            S_FETCH: begin
                if (imem_ready) begin
                    w_next_state = S_DECODE;
                end
            end
            S_DECODE: begin
                if (w_dec_halt) begin
                    w_next_state = S_HALTED;
                end else if (!w_dec_legal) begin
`ifdef ILLEGAL_TRAP_EN
                    w_next_state = S_TRAP;
                    w_set_fault  = 1'b1;
                    w_fault_code = FAULT_ILLEGAL;
`else
                    w_next_state = S_EXEC;
`endif
                end else begin
                    w_next_state = S_EXEC;
                end
            end
            S_EXEC: begin
                if (r_ctrl.branch || r_nop) begin
                    w_retire     = 1'b1;
                    w_next_state = S_FETCH;
                end else if (r_ctrl.mem_type != MEM_NONE) begin
                    w_next_state = S_MEM;
                end else begin
                    w_next_state = S_WB;
                end
            end
            S_MEM: begin
                // A completing access beats a timeout landing in the same cycle.
                if (dmem_ready) begin
                    if (w_is_load) begin
                        w_next_state = S_WB;
                    end else begin
                        w_retire     = 1'b1;
                        w_next_state = S_FETCH;
                    end
                end else if (r_wait == c_wait_last) begin
                    w_next_state = S_TRAP;
                    w_set_fault  = 1'b1;
                    w_fault_code = FAULT_TIMEOUT;
                end
            end
            S_WB: begin
                w_retire     = 1'b1;
                w_next_state = S_FETCH;
            end
            S_HALTED: begin
                w_next_state = S_HALTED;
            end
            S_TRAP: begin
                w_next_state = S_TRAP;
            end
            default: begin
                w_next_state = S_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_FETCH;
            r_ctrl    <= CTRL_NOP;
            r_nop     <= 1'b0;
            r_wait    <= '0;
            r_fault   <= FAULT_NONE;
            r_retired <= '0;
        end else begin
            r_state <= w_next_state;
            if (r_state == S_DECODE) begin
                r_ctrl <= w_dec_ctrl;
                r_nop  <= !w_dec_legal;
            end
            if ((r_state == S_MEM) && (w_next_state == S_MEM)) begin
                r_wait <= r_wait + 1'b1;
            end else begin
                r_wait <= '0;
            end
            if (w_set_fault) begin
                r_fault <= w_fault_code;
            end
            if (w_retire) begin
                r_retired <= r_retired + 1'b1;
            end
        end
    end

    // Strobes are held low while reset is asserted so the reset value is
    // observable before the first clock edge.
    always_comb begin
        imem_req = 1'b0;
        IRWrite  = 1'b0;
        PCWrite  = 1'b0;
        ALUSrc   = 1'b0;
        MemtoReg = 1'b0;
        RegWrite = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        Branch   = 1'b0;
        jal      = 1'b0;
        jalr     = 1'b0;
        ALUOp    = ALUOP_MEM;
        Halt     = 1'b0;
        busy     = 1'b1;
        if (!reset) begin
            case (r_state)
                S_FETCH: begin
                    imem_req = 1'b1;
                    IRWrite  = imem_ready;
                end
                S_EXEC: begin
                    Branch  = r_ctrl.branch;
                    PCWrite = r_ctrl.branch || r_nop;
                end
                S_MEM: begin
                    MemRead  = w_is_load;
                    MemWrite = w_is_store;
                    // A store retires in its completing MEM cycle.
                    PCWrite  = w_is_store && dmem_ready;
                end
                S_WB: begin
                    RegWrite = 1'b1;
                    PCWrite  = 1'b1;
                end
                S_HALTED: begin
                    Halt = 1'b1;
                    busy = 1'b0;
                end
                S_TRAP: begin
                    busy = 1'b0;
                end
                default: begin
                    busy = 1'b1;
                end
            endcase
            if ((r_state == S_EXEC) || (r_state == S_MEM) || (r_state == S_WB)) begin
                ALUSrc   = r_ctrl.alu_src;
                MemtoReg = r_ctrl.mem_to_reg;
                ALUOp    = r_ctrl.alu_op;
                jal      = r_ctrl.jal;
                jalr     = r_ctrl.jalr;
            end
        end
    end

    assign fault   = r_fault;
    assign retired = r_retired;

endmodule : multicycle_controller
`default_nettype wire
